// File: rtl/ysyx_23060187_decode_stage.sv
// RV32I/RV32E decode stage: decodes {pc, inst} on accept and queues the result
// in a small shift FIFO whose head drives the registered outputs.
module ysyx_23060187_decode_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter int RV32E     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [6:0]      opcode;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [XLEN-1:0] pc, input logic [31:0] inst);
        entry_t          e;
        logic [2:0]      fmt;
        logic            known;
        logic            rs1_u;
        logic            rs2_u;
        logic            rd_u;
        logic            rd_we;
        logic            bad_reg;
        logic [31:0]     imm32;
        logic [XLEN+31:0] ext;
        known = 1'b1;
        rs1_u = 1'b0;
        rs2_u = 1'b0;
        rd_u  = 1'b0;
        fmt   = FMT_NONE;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin fmt = FMT_U; rd_u = 1'b1; end
            OP_JAL:           begin fmt = FMT_J; rd_u = 1'b1; end
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
                fmt = FMT_I; rs1_u = 1'b1; rd_u = 1'b1;
            end
            OP_BRANCH:        begin fmt = FMT_B; rs1_u = 1'b1; rs2_u = 1'b1; end
            OP_STORE:         begin fmt = FMT_S; rs1_u = 1'b1; rs2_u = 1'b1; end
            OP_OP:            begin fmt = FMT_R; rs1_u = 1'b1; rs2_u = 1'b1; rd_u = 1'b1; end
            OP_MISC:          begin fmt = FMT_I; end
            default:          begin known = 1'b0; end
        endcase
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'd0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        ext     = {{XLEN{imm32[31]}}, imm32};
        rd_we   = rd_u && (inst[11:7] != 5'd0);
        // RV32E only has x0..x15; any live index with bit 4 set is unencodable
        bad_reg = (RV32E != 0) && ((rs1_u && inst[19]) || (rs2_u && inst[24]) || (rd_we && inst[11]));
        e.pc       = pc;
        e.rd       = inst[11:7];
        e.rs1      = inst[19:15];
        e.rs2      = inst[24:20];
        e.funct3   = inst[14:12];
        e.funct7b5 = inst[30];
        e.opcode   = inst[6:0];
        e.illegal  = (inst[1:0] != 2'b11) || !known || bad_reg;
        if (e.illegal) begin
            e.fmt    = FMT_NONE;
            e.imm    = '0;
            e.rs1_en = 1'b0;
            e.rs2_en = 1'b0;
            e.rd_we  = 1'b0;
        end else begin
            e.fmt    = fmt;
            e.imm    = ext[XLEN-1:0];
            e.rs1_en = rs1_u;
            e.rs2_en = rs2_u;
            e.rd_we  = rd_we;
        end
        return e;
    endfunction

    entry_t     buf_q  [BUF_DEPTH];
    entry_t     buf_d  [BUF_DEPTH];
    entry_t     next_s [BUF_DEPTH];
    entry_t     dec_s;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic [1:0] wr_idx_s;
    logic       ready_q;
    logic       ready_d;
    logic       valid_q;
    logic       valid_d;
    logic       push_s;
    logic       pop_s;

    assign dec_s    = decode(in_pc, in_inst);
    assign push_s   = in_valid && ready_q && !flush;
    assign pop_s    = (count_q != 2'd0) && out_ready && !flush;
    assign wr_idx_s = count_q - {1'b0, pop_s};

    // Shifted view of the buffer used when the head is popped
    for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_shift
        if (g == BUF_DEPTH - 1) begin : g_last
            assign next_s[g] = buf_q[g];
        end else begin : g_mid
            assign next_s[g] = buf_q[g+1];
        end
    end

    // Next-state for occupancy, ready, valid and buffer contents
    always_comb begin
        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
        ready_d = (count_d < DEPTH_C);
        valid_d = (count_d != 2'd0);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (push_s && (wr_idx_s == 2'(i))) begin
                buf_d[i] = dec_s;
            end else if (pop_s) begin
                buf_d[i] = next_s[i];
            end else begin
                buf_d[i] = buf_q[i];
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign out_pc       = buf_q[0].pc;
    assign out_rd       = buf_q[0].rd;
    assign out_rs1      = buf_q[0].rs1;
    assign out_rs2      = buf_q[0].rs2;
    assign out_funct3   = buf_q[0].funct3;
    assign out_funct7b5 = buf_q[0].funct7b5;
    assign out_opcode   = buf_q[0].opcode;
    assign out_fmt      = buf_q[0].fmt;
    assign out_imm      = buf_q[0].imm;
    assign out_rs1_en   = buf_q[0].rs1_en;
    assign out_rs2_en   = buf_q[0].rs2_en;
    assign out_rd_we    = buf_q[0].rd_we;
    assign out_illegal  = buf_q[0].illegal;

endmodule

// File: tb/tb_ysyx_23060187_decode_stage.sv
// Directed bench for the decode stage: a queue-based reference model checked
// every cycle, plus literal expectations for the RV32E and 64-bit variants.
module tb_ysyx_23060187_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;

    logic in_ready, out_valid, out_funct7b5, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [2:0] out_funct3, out_fmt;
    logic [6:0] out_opcode;

    logic e_in_ready, e_out_valid, e_out_funct7b5, e_out_rs1_en, e_out_rs2_en, e_out_rd_we, e_out_illegal;
    logic [31:0] e_out_pc, e_out_imm;
    logic [4:0] e_out_rd, e_out_rs1, e_out_rs2;
    logic [2:0] e_out_funct3, e_out_fmt;
    logic [6:0] e_out_opcode;

    logic w_in_ready, w_out_valid, w_out_funct7b5, w_out_rs1_en, w_out_rs2_en, w_out_rd_we, w_out_illegal;
    logic [63:0] w_out_pc, w_out_imm;
    logic [4:0] w_out_rd, w_out_rs1, w_out_rs2;
    logic [2:0] w_out_funct3, w_out_fmt;
    logic [6:0] w_out_opcode;

    ysyx_23060187_decode_stage #(.XLEN(32), .BUF_DEPTH(2), .RV32E(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_opcode(out_opcode),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal));

    ysyx_23060187_decode_stage #(.XLEN(32), .BUF_DEPTH(2), .RV32E(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_out_pc), .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2),
        .out_funct3(e_out_funct3), .out_funct7b5(e_out_funct7b5), .out_opcode(e_out_opcode),
        .out_fmt(e_out_fmt), .out_imm(e_out_imm), .out_rs1_en(e_out_rs1_en), .out_rs2_en(e_out_rs2_en),
        .out_rd_we(e_out_rd_we), .out_illegal(e_out_illegal));

    ysyx_23060187_decode_stage #(.XLEN(64), .BUF_DEPTH(2), .RV32E(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_pc({32'h0, in_pc}), .in_inst(in_inst), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_out_pc), .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
        .out_funct3(w_out_funct3), .out_funct7b5(w_out_funct7b5), .out_opcode(w_out_opcode),
        .out_fmt(w_out_fmt), .out_imm(w_out_imm), .out_rs1_en(w_out_rs1_en), .out_rs2_en(w_out_rs2_en),
        .out_rd_we(w_out_rd_we), .out_illegal(w_out_illegal));

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [6:0]  op;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        r1, r2, we, ill;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;
    exp_t mq[$];
    bit m_ready = 1'b1;
    logic [31:0] pop_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: opcode -> descriptor "<fmt><rs1><rs2><rd>", immediates by signed arithmetic
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] w, input bit rv32e);
        exp_t e;
        string d;
        bit bad;
        case (w[6:0])
            7'b0110111, 7'b0010111: d = "U001";
            7'b1101111: d = "J001";
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: d = "I101";
            7'b1100011: d = "B110";
            7'b0100011: d = "S110";
            7'b0110011: d = "R111";
            7'b0001111: d = "I000";
            default:    d = "";
        endcase
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.f3 = w[14:12]; e.f7 = w[30]; e.op = w[6:0];
        if (d == "") begin
            e.ill = 1'b1;
        end else begin
            e.r1 = (d[1] == "1");
            e.r2 = (d[2] == "1");
            e.we = (d[3] == "1") && (w[11:7] != 5'd0);
            bad = rv32e && ((e.r1 && e.rs1 >= 16) || (e.r2 && e.rs2 >= 16) || (e.we && e.rd >= 16));
            e.ill = (w[1:0] != 2'b11) || bad;
            case (d[0])
                "R": begin e.fmt = 3'd0; e.imm = 64'd0; end
                "I": begin e.fmt = 3'd1; e.imm = longint'($signed(w[31:20])); end
                "S": begin e.fmt = 3'd2; e.imm = longint'($signed({w[31:25], w[11:7]})); end
                "B": begin e.fmt = 3'd3; e.imm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
                "U": begin e.fmt = 3'd4; e.imm = longint'($signed(w[31:12])) * 4096; end
                default: begin e.fmt = 3'd5; e.imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            endcase
        end
        if (e.ill) begin
            e.fmt = 3'd7; e.imm = 64'd0; e.r1 = 1'b0; e.r2 = 1'b0; e.we = 1'b0;
        end
        return e;
    endfunction

    // Model occupancy follows the handshake rules; DUT outputs are never read here
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            mq.delete();
            m_ready = 1'b1;
        end else begin
            bit pu, po;
            pu = in_valid && m_ready;
            po = (mq.size() != 0) && out_ready;
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(model({32'h0, in_pc}, in_inst, 1'b0));
            m_ready = (mq.size() < 2);
        end
    end

    // Per-cycle comparison of the main DUT against the model
    always @(negedge clk) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
        if (mq.size() != 0 && out_valid) begin
            check("out_pc", {32'd0, out_pc}, mq[0].pc);
            check("out_rd", {59'd0, out_rd}, {59'd0, mq[0].rd});
            check("out_rs1", {59'd0, out_rs1}, {59'd0, mq[0].rs1});
            check("out_rs2", {59'd0, out_rs2}, {59'd0, mq[0].rs2});
            check("out_funct3", {61'd0, out_funct3}, {61'd0, mq[0].f3});
            check("out_funct7b5", {63'd0, out_funct7b5}, {63'd0, mq[0].f7});
            check("out_opcode", {57'd0, out_opcode}, {57'd0, mq[0].op});
            check("out_fmt", {61'd0, out_fmt}, {61'd0, mq[0].fmt});
            check("out_imm", {32'd0, out_imm}, {32'd0, mq[0].imm[31:0]});
            check("out_rs1_en", {63'd0, out_rs1_en}, {63'd0, mq[0].r1});
            check("out_rs2_en", {63'd0, out_rs2_en}, {63'd0, mq[0].r2});
            check("out_rd_we", {63'd0, out_rd_we}, {63'd0, mq[0].we});
            check("out_illegal", {63'd0, out_illegal}, {63'd0, mq[0].ill});
        end
        if (out_valid && out_ready) pop_log.push_back(out_pc);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        exp_t e;
        int budget;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 32'h0; in_inst = 32'h0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
        check("rst_out_imm", {32'd0, out_imm}, 64'd0);
        check("rst_out_opcode", {57'd0, out_opcode}, 64'd0);
        step();
        rst_n = 1'b1;

        e = model(64'd0, 32'hFE208EE3, 1'b0);
        check("pin_beq_imm", e.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        e = model(64'd0, 32'h800002B7, 1'b0);
        check("pin_lui_imm", e.imm, 64'hFFFF_FFFF_8000_0000);
        e = model(64'd0, 32'h00208833, 1'b1);
        check("pin_rv32e_ill", {63'd0, e.ill}, 64'd1);

        // addi x1,x0,-1
        drive(32'h8000_0000, 32'hFFF00093);
        step();
        in_valid = 1'b0;
        check("addi_valid", {63'd0, out_valid}, 64'd1);
        check("addi_fmt", {61'd0, out_fmt}, 64'd1);
        check("addi_rd", {59'd0, out_rd}, 64'd1);
        check("addi_rs1", {59'd0, out_rs1}, 64'd0);
        check("addi_imm", {32'd0, out_imm}, 64'h0000_0000_FFFF_FFFF);
        check("addi_rs1_en", {63'd0, out_rs1_en}, 64'd1);
        check("addi_rd_we", {63'd0, out_rd_we}, 64'd1);
        check("addi_illegal", {63'd0, out_illegal}, 64'd0);
        step();
        check("addi_drained", {63'd0, out_valid}, 64'd0);

        // Back-to-back stream with out_ready=1: head is always the latest push
        drive(32'h100, 32'hFE208EE3); step();
        check("beq_fmt", {61'd0, out_fmt}, 64'd3);
        check("beq_imm", {32'd0, out_imm}, 64'h0000_0000_FFFF_FFFC);
        check("beq_en", {61'd0, out_rs1_en, out_rs2_en, out_rd_we}, 64'd6);
        drive(32'h104, 32'h123452B7); step();
        check("lui_imm", {32'd0, out_imm}, 64'h0000_0000_1234_5000);
        check("lui_rd", {59'd0, out_rd}, 64'd5);
        drive(32'h108, 32'h800002B7); step();
        check("lui64_imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui32_imm", {32'd0, out_imm}, 64'h0000_0000_8000_0000);
        drive(32'h10C, 32'h00208833); step();
        check("add16_legal", {63'd0, out_illegal}, 64'd0);
        check("add16_fmt", {61'd0, out_fmt}, 64'd0);
        check("add16_e_illegal", {63'd0, e_out_illegal}, 64'd1);
        check("add16_e_fmt", {61'd0, e_out_fmt}, 64'd7);
        drive(32'h110, 32'h00000000); step();
        check("zero_illegal", {63'd0, out_illegal}, 64'd1);
        check("zero_fmt", {61'd0, out_fmt}, 64'd7);
        check("zero_en", {61'd0, out_rs1_en, out_rs2_en, out_rd_we}, 64'd0);
        drive(32'h114, 32'h00000013); step();
        check("nop_rd_we", {63'd0, out_rd_we}, 64'd0);
        check("nop_rs1_en", {63'd0, out_rs1_en}, 64'd1);
        check("nop_imm", {32'd0, out_imm}, 64'd0);
        in_valid = 1'b0;
        step(); step();

        // Back-pressure: A, B fill the buffer, C is held
        out_ready = 1'b0;
        pop_log.delete();
        drive(32'h200, 32'h00100093); step();
        drive(32'h204, 32'h00200113); step();
        drive(32'h208, 32'h00300193); step();
        check("bp_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_head_a", {32'd0, out_pc}, 64'h200);
        step();
        check("bp_head_stable", {32'd0, out_pc}, 64'h200);
        check("bp_imm_stable", {32'd0, out_imm}, 64'd1);
        out_ready = 1'b1;
        budget = 0;
        while (!in_ready && budget < 10) begin
            step();
            budget++;
        end
        check("bp_ready_timeout", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("bp_pop_count", 64'(pop_log.size()), 64'd3);
        check("bp_order_a", {32'd0, pop_log.size() > 0 ? pop_log[0] : 32'hX}, 64'h200);
        check("bp_order_b", {32'd0, pop_log.size() > 1 ? pop_log[1] : 32'hX}, 64'h204);
        check("bp_order_c", {32'd0, pop_log.size() > 2 ? pop_log[2] : 32'hX}, 64'h208);

        // Flush with a full buffer and a pending push
        out_ready = 1'b0;
        drive(32'h300, 32'h00100093); step();
        drive(32'h304, 32'h00200113); step();
        drive(32'h308, 32'h00300193);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ready", {63'd0, in_ready}, 64'd1);
        // Flush with a same-cycle accept that must be dropped
        drive(32'h30C, 32'h00100093); step();
        drive(32'h310, 32'h00200113);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_valid", {63'd0, out_valid}, 64'd0);
        drive(32'h314, 32'h00400213); step();
        in_valid = 1'b0;
        check("post_flush_valid", {63'd0, out_valid}, 64'd1);
        check("post_flush_pc", {32'd0, out_pc}, 64'h314);
        out_ready = 1'b1;
        step(); step();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(32'h400, 32'h00100093); step();
        drive(32'h404, 32'h00200113); step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {63'd0, out_valid}, 64'd0);
        check("areset_ready", {63'd0, in_ready}, 64'd1);
        check("areset_pc", {32'd0, out_pc}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_empty", {63'd0, out_valid}, 64'd0);
        drive(32'h408, 32'h00500293); step();
        in_valid = 1'b0;
        check("post_reset_pc", {32'd0, out_pc}, 64'h408);
        out_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_decode_stage.md
Name: ysyx_23060187_decode_stage

Overview:
- Registered RV32I/RV32E decode stage between IFU and EXU: full field extraction, all five immediate formats, register-use enables and an illegal-instruction flag.
- Accepts {pc, inst} on a valid/ready handshake and buffers decoded results in a BUF_DEPTH-entry FIFO, so in_ready is registered and back-pressure is handled without a combinational path.
- Immediates and pc are XLEN wide.

Parameters:
- XLEN, 32: datapath width; immediates sign-extended to XLEN. Legal values are 32 and 64.
- BUF_DEPTH, 2: output FIFO entries. Legal values are 1 and 2.
- RV32E, 0: when 1, any used register index ≥16 raises illegal.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  drop all buffered entries and any same-cycle accept.
- in_valid  in  1  upstream {pc, inst} valid.
- in_ready  out  1  stage can accept (registered).
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_pc  out  XLEN  pc of head entry.
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7b5  out  1  inst[30].
- out_opcode  out  7  inst[6:0].
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none/illegal.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1_en, out_rs2_en, out_rd_we  out  1 each  register-use enables.
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; out_valid=0; in_ready=1; all out_* data fields=0. Release is synchronous to the next clk edge.
- Accept: when in_valid & in_ready at a posedge, decode in_inst combinationally and push the result. Latency is exactly 1 cycle: out_valid=1 in the following cycle if the FIFO was empty.
- Pop: when out_valid & out_ready at a posedge, the head is removed. FIFO order is preserved.
- in_ready = (count < BUF_DEPTH), registered.
  - When full, no push occurs even if a pop happens in the same cycle; ready rises the cycle after the pop.
  - A simultaneous push and pop when not full leaves the count unchanged.
- out_* data are held stable while out_valid & !out_ready.
- flush: at the next posedge, count=0 and out_valid=0; a same-cycle accept is discarded; in_ready=1 after that edge. flush has priority over push and pop.
- Opcode table (fmt / rs1_en rs2_en rd_we):
  - LUI 0110111 and AUIPC 0010111: U / 0 0 1.
  - JAL 1101111: J / 0 0 1.
  - JALR 1100111: I / 1 0 1.
  - BRANCH 1100011: B / 1 1 0.
  - LOAD 0000011: I / 1 0 1.
  - STORE 0100011: S / 1 1 0.
  - OP-IMM 0010011: I / 1 0 1.
  - OP 0110011: R / 1 1 1.
  - MISC-MEM 0001111: I / 0 0 0.
  - SYSTEM 1110011: I / 1 0 1.
- rd_we is forced to 0 when rd==0.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All are sign-extended from their MSB to XLEN. For R format, imm=0.
- Illegal conditions:
  - inst[1:0] != 2'b11, or
  - opcode not in the table, or
  - RV32E=1 and any enabled register index (rs1 if rs1_en, rs2 if rs2_en, rd if rd≠0 and used) has bit 4 set.
- An illegal entry is still queued, with:
  - illegal=1, fmt=7, imm=0;
  - rs1_en, rs2_en, rd_we all 0;
  - raw fields (rd, rs1, rs2, funct3, funct7b5, opcode) and pc passed through.

Test Plan:
- Reset, then push addi x1,x0,-1 (0xFFF00093), pc=0x80000000, out_ready=1 → next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF, rs1_en=1, rd_we=1, illegal=0. out_valid=0 the cycle after.
- beq x1,x2,-4 (0xFE208EE3) → fmt=3, imm=0xFFFFFFFC, rs1_en=rs2_en=1, rd_we=0. lui x5,0x12345 (0x123452B7) → imm=0x12345000. With XLEN=64, lui x5,0x80000 (0x800002B7) → imm=0xFFFFFFFF80000000.
- Back-pressure with BUF_DEPTH=2, out_ready=0, three back-to-back pushes A,B,C → A,B accepted, in_ready=0 and C held. Raise out_ready → A, B, C emerge in order with no loss or duplication; out_* stays stable while stalled.
- 0x00000000 → illegal=1, fmt=7, all enables 0. With RV32E=1, add x16,x1,x2 (0x00208833) → illegal=1. With RV32E=0, the same word → legal, fmt=0.
- flush with 2 entries queued plus a concurrent push → next cycle out_valid=0, in_ready=1; a new push emerges 1 cycle later. Assert rst_n=0 mid-stream → out_valid drops immediately (asynchronously), FIFO empty after release.
- addi x0,x0,0 (0x00000013) → rd_we=0, rs1_en=1, imm=0.
